// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - three-line nested-priority interrupt controller with return stack
module int_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_1000,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  IR,
    input  logic        mask_we,
    input  logic [2:0]  mask_wd,
    input  logic        ie_set,
    input  logic        ie_clr,
    input  logic        pipe_ready,
    input  logic [31:0] pc_in,
    input  logic        eret,
    output logic        int_take,
    output logic [31:0] int_vec,
    output logic        int_ret,
    output logic [31:0] ret_pc,
    output logic        Clr,
    output logic [2:0]  ClrInt,
    output logic [1:0]  cur_level,
    output logic        IE,
    output logic [2:0]  mask
);

    typedef enum logic [1:0] {RUN, ENTER, EXIT} state_t;

    state_t      state;
    logic [1:0]  depth;
    logic [33:0] stack [0:2];

    logic [2:0]  pend;
    logic        win_vld;
    logic [1:0]  win_idx;
    logic        take;
    logic        do_ret;
    logic [33:0] top;

    always_comb begin
        pend    = IR & mask;
        win_vld = |pend;
        win_idx = 2'd0;
        if (pend[2])      win_idx = 2'd2;
        else if (pend[1]) win_idx = 2'd1;
    end

    // Levels strictly increase on entry, so a full stack can never satisfy take.
    assign take   = (state == RUN) && IE && pipe_ready && win_vld
                    && ({1'b0, win_idx} + 3'd1 > {1'b0, cur_level}) && (depth != 2'd3);
    assign do_ret = (state == RUN) && eret && (depth != 2'd0);
    assign top    = stack[depth - 2'd1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            depth     <= 2'd0;
            cur_level <= 2'd0;
            IE        <= 1'b0;
            mask      <= 3'b111;
            ret_pc    <= 32'd0;
            int_take  <= 1'b0;
            int_vec   <= 32'd0;
            int_ret   <= 1'b0;
            Clr       <= 1'b0;
            ClrInt    <= 3'b000;
        end else begin
            int_take <= 1'b0;
            int_vec  <= 32'd0;
            int_ret  <= 1'b0;
            Clr      <= 1'b0;
            ClrInt   <= 3'b000;
            state    <= RUN;

            if (mask_we) mask <= mask_wd;
            if (ie_clr)      IE <= 1'b0;
            else if (ie_set) IE <= 1'b1;

            // Return has priority; a pending take is re-examined after EXIT.
            if (do_ret) begin
                depth     <= depth - 2'd1;
                cur_level <= top[33:32];
                ret_pc    <= top[31:0];
                IE        <= 1'b1;
                int_ret   <= 1'b1;
                state     <= EXIT;
            end else if (take) begin
                stack[depth] <= {cur_level, pc_in};
                depth        <= depth + 2'd1;
                cur_level    <= win_idx + 2'd1;
                IE           <= 1'b0;
                int_take     <= 1'b1;
                int_vec      <= VEC_BASE + 32'(win_idx) * VEC_STRIDE;
                Clr          <= 1'b1;
                ClrInt       <= 3'b001 << win_idx;
                state        <= ENTER;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  IR;
    logic        mask_we;
    logic [2:0]  mask_wd;
    logic        ie_set;
    logic        ie_clr;
    logic        pipe_ready;
    logic [31:0] pc_in;
    logic        eret;
    logic        int_take;
    logic [31:0] int_vec;
    logic        int_ret;
    logic [31:0] ret_pc;
    logic        Clr;
    logic [2:0]  ClrInt;
    logic [1:0]  cur_level;
    logic        IE;
    logic [2:0]  mask;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk(clk), .rst(rst), .IR(IR), .mask_we(mask_we), .mask_wd(mask_wd),
        .ie_set(ie_set), .ie_clr(ie_clr), .pipe_ready(pipe_ready), .pc_in(pc_in),
        .eret(eret), .int_take(int_take), .int_vec(int_vec), .int_ret(int_ret),
        .ret_pc(ret_pc), .Clr(Clr), .ClrInt(ClrInt), .cur_level(cur_level),
        .IE(IE), .mask(mask)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; IR = 3'b000; mask_we = 1'b0; mask_wd = 3'b000;
        ie_set = 1'b0; ie_clr = 1'b0; pipe_ready = 1'b1; pc_in = 32'h0; eret = 1'b0;
        tick(); tick();
        check("rst_level", 32'(cur_level), 0);
        check("rst_ie",    32'(IE), 0);
        check("rst_mask",  32'(mask), 32'h7);
        check("rst_take",  32'(int_take), 0);
        check("rst_ret",   32'(int_ret), 0);
        check("rst_retpc", ret_pc, 0);
        check("rst_clr",   32'(Clr), 0);

        // Line 0 entry from idle
        rst = 1'b1; ie_set = 1'b1; tick(); ie_set = 1'b0;
        check("ie_set", 32'(IE), 1);
        IR = 3'b001; pc_in = 32'h100; tick();
        check("l0_take",   32'(int_take), 1);
        check("l0_vec",    int_vec, 32'h1000);
        check("l0_clrint", 32'(ClrInt), 32'h1);
        check("l0_clr",    32'(Clr), 1);
        check("l0_level",  32'(cur_level), 1);
        check("l0_ie",     32'(IE), 0);
        IR = 3'b000; tick();
        check("enter_1cyc", 32'(int_take), 0);

        // Nest line 2, then unwind twice
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        IR = 3'b100; pc_in = 32'h200; tick();
        check("l2_take",  32'(int_take), 1);
        check("l2_vec",   int_vec, 32'h1020);
        check("l2_level", 32'(cur_level), 3);
        check("l2_clrint", 32'(ClrInt), 32'h4);
        IR = 3'b000; tick();
        eret = 1'b1; tick();
        check("ret1_pulse", 32'(int_ret), 1);
        check("ret1_pc",    ret_pc, 32'h200);
        check("ret1_level", 32'(cur_level), 1);
        check("ret1_ie",    32'(IE), 1);
        eret = 1'b0; tick();
        check("exit_1cyc", 32'(int_ret), 0);
        check("retpc_hold", ret_pc, 32'h200);
        eret = 1'b1; tick(); eret = 1'b0;
        check("ret0_pc",    ret_pc, 32'h100);
        check("ret0_level", 32'(cur_level), 0);
        tick();

        // Masked line 2 loses to enabled line 1
        mask_we = 1'b1; mask_wd = 3'b011; tick(); mask_we = 1'b0;
        check("mask_wr", 32'(mask), 32'h3);
        IR = 3'b110; pc_in = 32'h300; tick();
        check("m_take",   32'(int_take), 1);
        check("m_vec",    int_vec, 32'h1010);
        check("m_clrint", 32'(ClrInt), 32'h2);
        check("m_level",  32'(cur_level), 2);
        IR = 3'b000; tick();
        mask_we = 1'b1; mask_wd = 3'b111; ie_set = 1'b1; tick();
        mask_we = 1'b0; ie_set = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        check("m_retpc", ret_pc, 32'h300);
        tick();

        // ie_clr beats ie_set; no take while IE=0 or pipe not ready
        ie_set = 1'b1; ie_clr = 1'b1; tick(); ie_set = 1'b0; ie_clr = 1'b0;
        check("ie_clr_wins", 32'(IE), 0);
        IR = 3'b001; tick();
        check("no_take_ie0", 32'(int_take), 0);
        IR = 3'b000; ie_set = 1'b1; tick(); ie_set = 1'b0;
        IR = 3'b001; pipe_ready = 1'b0; tick();
        check("no_take_pipe", 32'(int_take), 0);
        pipe_ready = 1'b1; IR = 3'b000;

        // Level 3 blocks lower line; eret at depth 0 ignored
        IR = 3'b100; pc_in = 32'h400; tick();
        check("l3_level", 32'(cur_level), 3);
        IR = 3'b000; tick();
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        IR = 3'b010; tick();
        check("l3_block", 32'(int_take), 0);
        check("l3_hold",  32'(cur_level), 3);
        IR = 3'b000; eret = 1'b1; tick(); eret = 1'b0;
        check("l3_retpc", ret_pc, 32'h400);
        tick();
        eret = 1'b1; tick(); eret = 1'b0;
        check("d0_noret",   32'(int_ret), 0);
        check("d0_level",   32'(cur_level), 0);
        check("d0_retpc",   ret_pc, 32'h400);

        // Simultaneous eret and take: return first, take after EXIT
        IR = 3'b001; pc_in = 32'h500; tick();
        check("s_take0", 32'(int_take), 1);
        IR = 3'b000; tick();
        ie_set = 1'b1; tick(); ie_set = 1'b0;
        IR = 3'b100; eret = 1'b1; tick(); eret = 1'b0;
        check("s_ret",      32'(int_ret), 1);
        check("s_notake",   32'(int_take), 0);
        check("s_retpc",    ret_pc, 32'h500);
        tick();
        check("s_exit_idle", 32'(int_take), 0);
        tick();
        check("s_take",  32'(int_take), 1);
        check("s_vec",   int_vec, 32'h1020);

        // Reset mid-ENTER
        IR = 3'b000; rst = 1'b0; tick();
        check("mr_take",  32'(int_take), 0);
        check("mr_clr",   32'(Clr), 0);
        check("mr_level", 32'(cur_level), 0);
        check("mr_ie",    32'(IE), 0);
        check("mr_retpc", ret_pc, 0);
        check("mr_vec",   int_vec, 0);
        rst = 1'b1; eret = 1'b1; tick(); eret = 1'b0;
        check("mr_noret", 32'(int_ret), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_1000, meaning handler base address.
REQ-002 SHALL have parameter VEC_STRIDE, default 32'h0000_0010, meaning byte spacing between handler entries.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port IR  input  3  latched pending requests from the interrupt request register; bit 2 is highest priority.
REQ-006 SHALL have ports mask_we  input  1 and mask_wd  input  3  mask write strobe and data; mask bit 1 = line enabled.
REQ-007 SHALL have ports ie_set and ie_clr  input  1 each  global-enable set and clear strobes.
REQ-008 SHALL have port pipe_ready  input  1  pipeline is at an instruction boundary and accepts a redirect.
REQ-009 SHALL have port pc_in  input  32  resume PC to save on interrupt entry.
REQ-010 SHALL have port eret  input  1  return-from-interrupt retire pulse.
REQ-011 SHALL have ports int_take  output  1 and int_vec  output  32  entry redirect pulse and handler address.
REQ-012 SHALL have ports int_ret  output  1 and ret_pc  output  32  return redirect pulse and restored PC.
REQ-013 SHALL have ports Clr  output  1 and ClrInt  output  3  clear command and one-hot line select to the request register.
REQ-014 SHALL have ports cur_level  output  2 (0 = none, k = line k-1 in service), IE  output  1, mask  output  3.

Function
REQ-015 SHALL implement FSM states RUN, ENTER, EXIT; ENTER and EXIT last exactly one cycle and return to RUN.
REQ-016 SHALL, in RUN, select winner = highest set bit of IR & mask; take condition = IE & pipe_ready & winner exists & (winner index + 1) > cur_level.
REQ-017 SHALL, on a take-condition edge, push {cur_level, pc_in} onto a 3-entry stack, set cur_level = winner + 1, clear IE, latch the winner index, and enter ENTER.
REQ-018 SHALL, during ENTER, drive int_take = 1, int_vec = VEC_BASE + winner x VEC_STRIDE (32-bit, wrap modulo 2^32), Clr = 1, ClrInt = one-hot(winner); all are 0 in every other state.
REQ-019 SHALL, on an edge in RUN with eret = 1 and stack depth > 0, pop the stack, restore cur_level from the popped entry, set IE = 1, and enter EXIT.
REQ-020 SHALL, during EXIT, drive int_ret = 1 and ret_pc = popped PC; ret_pc SHALL hold its last value otherwise.
REQ-021 SHALL ignore eret when depth = 0 (no state change, no pulse).
REQ-022 SHALL give eret priority over a simultaneous take condition; the take is re-evaluated in RUN after EXIT.
REQ-023 SHALL not evaluate take or eret in ENTER or EXIT; requests arriving then remain in IR and are evaluated in the next RUN cycle.
REQ-024 SHALL bound stack depth at 3 by construction (levels strictly increase); no push SHALL occur when depth = 3.
REQ-025 SHALL evaluate take with pre-edge mask and IE; mask_we and ie_set/ie_clr take effect at the same edge; ie_clr wins over ie_set; hardware IE updates (REQ-017/019) override both strobes.
REQ-026 SHALL add 1 cycle of latency from a qualifying IR/pipe_ready sample to int_take.

Reset
REQ-027 SHALL, on an edge with rst = 0, set state RUN, depth 0, cur_level 0, IE 0, mask 3'b111, ret_pc 0, and all pulse outputs 0, overriding all other inputs including mid-ENTER/EXIT.

Verification
REQ-028 Reset, ie_set, IR=3'b001, pipe_ready=1 -> next cycle int_take=1, int_vec=32'h1000, ClrInt=3'b001, Clr=1, cur_level=1, IE=0.
REQ-029 In level 1, ie_set, IR=3'b100 -> int_take, int_vec=32'h1020, cur_level=3; then eret -> int_ret, ret_pc=level-1 resume PC, cur_level=1, IE=1.
REQ-030 IR=3'b110, mask_wd=3'b011 written earlier, IE=1 -> line 1 taken, int_vec=32'h1010, line 2 ignored.
REQ-031 cur_level=3, IE=1, IR=3'b010 -> no int_take; eret at depth 0 -> no int_ret, state unchanged.
REQ-032 eret and take condition same cycle -> int_ret first, int_take one cycle after EXIT; rst=0 during ENTER -> next cycle all outputs at reset values.
